pwm_fade_sequencer: RTL and testbench

Sequences the PWM peripheral's 8-bit duty cycle from its current value toward a programmed target in fixed-size steps at a programmed cycle interval, producing smooth fades on `pwm0` (`uo_out[0]`) and the other PWM-enabled outputs. It sits in the top-level user project between the SPI-written control registers (target, step, interval, start/abort strobes) and the PWM peripheral's duty input. It is the sole writer of the duty value driven to the PWM block.

---
 rtl/pwm_seq_pkg.sv | 29 ++
 rtl/interval_timer.sv | 34 +++
 rtl/pwm_fade_sequencer.sv | 112 +++++++++++
 tb/tb_pwm_fade_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared types, default widths and the saturating duty step for the fade sequencer
package pwm_seq_pkg;

  localparam int DEF_DUTY_W = 8;
  localparam int DEF_IVL_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  // Moves cur one step toward tgt and lands exactly on tgt instead of overshooting or wrapping.
  function automatic logic [DEF_DUTY_W-1:0] sat_step(
    input logic [DEF_DUTY_W-1:0] cur,
    input logic [DEF_DUTY_W-1:0] tgt,
    input logic [DEF_DUTY_W-1:0] stp
  );
    logic [DEF_DUTY_W:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    if (cur < tgt) begin
      return (sum > {1'b0, tgt}) ? tgt : sum[DEF_DUTY_W-1:0];
    end else if (stp > (cur - tgt)) begin
      return tgt;
    end else begin
      return cur - stp;
    end
  endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - loadable down-counter that paces fade steps
module interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - steps the PWM duty value toward a programmed target at a fixed interval
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int IVL_W  = DEF_IVL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [DUTY_W-1:0] step_size,
  input  logic [IVL_W-1:0]  interval,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_we,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] stp_q, stp_d;
  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              tmr_load;
  logic [IVL_W-1:0]  tmr_val;
  logic              tmr_zero;

  interval_timer #(.W(IVL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ena && (state_q == RAMP)),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    tgt_d    = tgt_q;
    stp_d    = stp_q;
    ivl_d    = ivl_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = ivl_q - IVL_W'(1);
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            tgt_d    = target_duty;
            stp_d    = (step_size == '0) ? DUTY_W'(1) : step_size;
            ivl_d    = (interval == '0) ? IVL_W'(1) : interval;
            tmr_load = 1'b1;
            tmr_val  = ivl_d - IVL_W'(1);
            if (target_duty == duty_q) begin
              done_d = 1'b1;
            end else begin
              state_d = RAMP;
            end
          end
        end
        RAMP: begin
          if (abort) begin
            state_d = IDLE;
          end else if (tmr_zero) begin
            duty_d = sat_step(duty_q, tgt_q, stp_q);
            we_d   = 1'b1;
            if (duty_d == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              tmr_load = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      stp_q   <= '0;
      ivl_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      ivl_q   <= ivl_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign duty_we  = we_q;
  assign busy     = (state_q == RAMP);
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - directed timelines plus randomized traffic against a fade model
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic        abort;
  logic [7:0]  target_duty;
  logic [7:0]  step_size;
  logic [15:0] interval;
  logic [7:0]  duty_out;
  logic        duty_we;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  pwm_fade_sequencer #(.DUTY_W(8), .IVL_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start),
    .abort       (abort),
    .target_duty (target_duty),
    .step_size   (step_size),
    .interval    (interval),
    .duty_out    (duty_out),
    .duty_we     (duty_we),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Model: a fade is a schedule of steps, one every N enabled clock edges after acceptance.
  int     m_duty = 0, m_tgt = 0, m_stp = 1, m_ivl = 1;
  bit     m_busy = 0, m_we = 0, m_done = 0;
  longint ecnt = 0, m_next = 0;

  always @(posedge clk) begin
    m_we   = 0;
    m_done = 0;
    if (!rst_n) begin
      m_duty = 0;
      m_busy = 0;
    end else if (ena) begin
      ecnt++;
      if (m_busy) begin
        if (abort) begin
          m_busy = 0;
        end else if (ecnt == m_next) begin
          if (m_duty < m_tgt) m_duty = (m_duty + m_stp > m_tgt) ? m_tgt : m_duty + m_stp;
          else                m_duty = (m_duty - m_tgt < m_stp) ? m_tgt : m_duty - m_stp;
          m_we = 1;
          if (m_duty == m_tgt) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_next = ecnt + m_ivl;
          end
        end
      end else if (start && !abort) begin
        m_tgt = int'(target_duty);
        m_stp = (step_size == 0) ? 1 : int'(step_size);
        m_ivl = (interval == 0) ? 1 : int'(interval);
        if (m_tgt == m_duty) m_done = 1;
        else begin
          m_busy = 1;
          m_next = ecnt + m_ivl;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if (duty_out !== 8'(m_duty) || duty_we !== m_we || busy !== m_busy || done !== m_done) begin
          miscompares++;
          $display("FAIL model t=%0t duty=%0d exp %0d we=%b exp %b busy=%b exp %b done=%b exp %b",
                   $time, duty_out, m_duty, duty_we, m_we, busy, m_busy, done, m_done);
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic go(input int t, input int s, input int i);
    target_duty = 8'(t);
    step_size   = 8'(s);
    interval    = 16'(i);
    start       = 1'b1;
    tick(1);
    start       = 1'b0;
  endtask

  int we_cnt, done_cnt;
  int up_exp[18];
  int dn_exp[5];

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    target_duty = 8'd0; step_size = 8'd0; interval = 16'd0;
    tick(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick(1);
    chk("reset_duty", int'(duty_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    up_exp = '{0, 0, 0, 0, 0, 30, 30, 30, 30, 60, 60, 60, 60, 90, 90, 90, 90, 100};
    go(100, 30, 4);
    we_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) tick(1);
      we_cnt += int'(duty_we);
      if (k <= 17) chk($sformatf("up_duty_c%0d", k), int'(duty_out), up_exp[k]);
      if (k == 16 || k == 17) chk($sformatf("up_done_c%0d", k), int'(done), (k == 17) ? 1 : 0);
    end
    chk("up_we_pulses", we_cnt, 4);

    dn_exp = '{0, 100, 99, 98, 97};
    go(97, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick(1);
      chk($sformatf("down_duty_c%0d", k), int'(duty_out), dn_exp[k]);
    end
    chk("down_done", int'(done), 1);
    tick(2);

    go(250, 200, 1);
    tick(3);
    go(255, 200, 1);
    tick(1);
    chk("sat_duty", int'(duty_out), 255);
    chk("sat_done", int'(done), 1);
    tick(2);

    go(0, 10, 3);
    tick(4);
    rst_n = 1'b0;
    tick(3);
    chk("midreset_duty", int'(duty_out), 0);
    chk("midreset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(1);

    go(100, 30, 4);
    tick(4);
    chk("abort_step1", int'(duty_out), 30);
    tick(1);
    target_duty = 8'd10; step_size = 8'd1; interval = 16'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("abort_step2", int'(duty_out), 60);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    done_cnt = int'(done);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      done_cnt += int'(done);
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_hold", int'(duty_out), 60);

    go(60, 5, 3);
    chk("noop_done", int'(done), 1);
    chk("noop_busy", int'(busy), 0);
    tick(1);

    go(120, 30, 4);
    tick(1);
    ena = 1'b0;
    tick(10);
    ena = 1'b1;
    tick(2);
    chk("ena_shift_c14", int'(duty_out), 60);
    tick(1);
    chk("ena_shift_c15", int'(duty_out), 90);
    tick(4);
    chk("ena_shift_c19", int'(duty_out), 120);
    chk("ena_shift_done", int'(done), 1);

    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      ena         = ($urandom_range(0, 9) != 0);
      start       = ($urandom_range(0, 5) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      target_duty = 8'($urandom_range(0, 255));
      step_size   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
      interval    = 16'($urandom_range(0, 4));
      tick(1);
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; ena = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
